panda_id_ex_stage: RTL
======================

# panda_id_ex_stage

Decode-to-execute pipeline stage of the Panda core. It accepts one decoded instruction per cycle from decode and resolves source operands with forwarding from the EX result and the WB write port. It registers the ALU operator and the final operand A/B values that drive `panda_alu` directly. It also detects load-use hazards, inserts a one-cycle bubble for them, and applies pipeline flushes.

## Interface
Parameters:
- `Width`, 32, datapath width; also PC, immediate and register-data width.

Ports:
- `clk_i`  in  1  core clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  kill the held instruction and refuse the incoming one.
- `id_valid_i`  in  1  decode presents an instruction.
- `id_ready_o`  out  1  stage accepts the presented instruction this cycle.
- `id_operator_i`  in  `panda_pkg::alu_operator_e`  ALU operation.
- `id_rs1_i`, `id_rs2_i`, `id_rd_i`  in  5 each  register indices.
- `id_rs_used_i`  in  2  bit0: rs1 read, bit1: rs2 read (for hazards).
- `id_rd_we_i`  in  1  instruction writes rd.
- `id_is_load_i`  in  1  instruction is a load.
- `id_op_a_sel_i`  in  1  0: rs1 data, 1: `id_pc_i`.
- `id_op_b_sel_i`  in  1  0: rs2 data, 1: `id_imm_i`.
- `id_pc_i`, `id_imm_i`  in  Width each  PC and sign-extended immediate.
- `rf_rdata_a_i`, `rf_rdata_b_i`  in  Width each  register-file read data for rs1 and rs2.
- `alu_result_i`  in  Width  current `panda_alu` result (EX forward source).
- `wb_we_i`  in  1  WB writes the register file this cycle.
- `wb_rd_i`  in  5  WB destination register.
- `wb_data_i`  in  Width  WB write data.
- `ex_ready_i`  in  1  EX consumes the held instruction.
- `ex_valid_o`  out  1  held instruction is valid.
- `ex_operator_o`  out  `alu_operator_e`  feeds `panda_alu` `operator_i`.
- `ex_operand_a_o`, `ex_operand_b_o`  out  Width each  feed the ALU operands.
- `ex_rs2_data_o`  out  Width  forwarded rs2 value (store data).
- `ex_rd_o`  out  5  destination register of the held instruction.
- `ex_rd_we_o`  out  1  write-enable of the held instruction.
- `ex_is_load_o`  out  1  load flag of the held instruction.

## Operation
- Transfer occurs when `id_valid_i && id_ready_o`. The resolved values are captured into the output register at the next edge, and `ex_valid_o` is set to 1.
- `id_ready_o = !flush_i && !hazard && (!ex_valid_o || ex_ready_i)`.
- `hazard = ex_valid_o && ex_is_load_o && ex_rd_we_o && ex_rd_o != 0 && ((id_rs_used_i[0] && id_rs1_i == ex_rd_o) || (id_rs_used_i[1] && id_rs2_i == ex_rd_o))`.
- Operand resolution is done per source (rs1, rs2) in strict priority order:
  1. If the index is 0, the value is 0. No forwarding.
  2. If `ex_valid_o && ex_rd_we_o && !ex_is_load_o && ex_rd_o == idx`, the value is `alu_result_i`.
  3. If `wb_we_i && wb_rd_i == idx`, the value is `wb_data_i`.
  4. Otherwise the value is from `rf_rdata_*_i`. These inputs reflect register-file writes from prior cycles only.
- Operand A is the resolved rs1 value, or `id_pc_i` when `id_op_a_sel_i` is set.
- Operand B is the resolved rs2 value, or `id_imm_i` when `id_op_b_sel_i` is set.
- `ex_rs2_data_o` always carries the resolved rs2 value.
- When EX consumes (`ex_valid_o && ex_ready_i`) and no transfer happens, `ex_valid_o` goes to 0. This is a bubble. Payload registers may hold stale data.
- When EX stalls (`ex_valid_o && !ex_ready_i`), all output registers hold their values.
- Flush: if `flush_i` is high at an edge, then `ex_valid_o` goes to 0 and no transfer occurs, regardless of the other inputs.
- Reset values: `ex_valid_o`=0, `ex_operator_o`=`ALU_ADD`, and all other registered outputs are 0.
- Reset may assert mid-operation. It clears the stage immediately, without waiting for a clock edge, and in-flight data is discarded.

## Timing
- Latency is one cycle from an accepted `id_valid_i` to `ex_valid_o`.
- Throughput is one instruction per cycle when there is no hazard and `ex_ready_i`=1.
- A load-use hazard costs exactly one bubble:
  - Cycle N: `id_ready_o`=0.
  - At the N+1 edge the load leaves EX and `ex_valid_o` drops.
  - Cycle N+1: the dependent instruction is accepted with the load data forwarded from `wb_data_i`.
- Combinational paths:
  - `id_ready_o` depends on `flush_i`, `ex_ready_i`, the ID indices and the output register.
  - The operand muxes depend on `alu_result_i`. This is an ALU-to-register path, so no combinational loop exists.
- When EX-source and WB-source forwarding match in the same cycle, the EX value wins.

## Test plan
- Back-to-back independent ops: three ADDs offered on consecutive cycles with `ex_ready_i`=1. Required: `id_ready_o` stays at 1, and the outputs appear one cycle after each transfer with zero bubbles.
- EX forward: `ADD x5` held in EX with `alu_result_i`=0x10, then `SUB x6,x5,x5` presented while the register file returns 0xDEAD. Required: both operands captured as 0x10.
- Load-use: a load to x7 held in EX, then `ADD x8,x7,x1` presented. Required:
  - `id_ready_o`=0 for one cycle, then `ex_valid_o`=0 for one cycle.
  - Next, with `wb_we_i`=1, `wb_rd_i`=7 and `wb_data_i`=0x55, the ADD is accepted with `ex_operand_a_o`=0x55.
- x0 and priority: rs1=0 with EX and WB both writing x0 with 0xFF. Required: operand 0. Separately, EX and WB both targeting x3, EX=1 and WB=2. Required: operand 1.
- Stall and flush:
  - `ex_ready_i`=0 for 3 cycles. Required: outputs held and `id_ready_o`=0.
  - Then `flush_i`=1 together with `id_valid_i`=1. Required: `ex_valid_o`=0 next cycle and nothing captured.
- Async reset mid-stream: assert `rst_ni`=0 between edges while `ex_valid_o`=1. Required: all outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/panda_id_ex_stage.sv
// rtl/panda_id_ex_stage.sv - Panda decode-to-execute stage with operand forwarding and load-use stall
//
// panda_pkg           : ALU operator encoding shared with panda_alu.
// panda_id_ex_stage
//   clk_i, rst_ni     : core clock, asynchronous active-low reset
//   flush_i           : drop held instruction, refuse incoming one
//   id_*              : decoded instruction handshake and payload
//   rf_rdata_a/b_i    : register-file read data for rs1/rs2
//   alu_result_i      : EX forward source
//   wb_we/rd/data_i   : WB forward source
//   ex_ready_i        : EX consumes the held instruction
//   ex_*_o            : registered instruction presented to EX

package panda_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_operator_e;

endpackage

module panda_id_ex_stage
  import panda_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,

  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  alu_operator_e        id_operator_i,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic [4:0]           id_rd_i,
  input  logic [1:0]           id_rs_used_i,
  input  logic                 id_rd_we_i,
  input  logic                 id_is_load_i,
  input  logic                 id_op_a_sel_i,
  input  logic                 id_op_b_sel_i,
  input  logic [Width-1:0]     id_pc_i,
  input  logic [Width-1:0]     id_imm_i,

  input  logic [Width-1:0]     rf_rdata_a_i,
  input  logic [Width-1:0]     rf_rdata_b_i,

  input  logic [Width-1:0]     alu_result_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_rd_i,
  input  logic [Width-1:0]     wb_data_i,

  input  logic                 ex_ready_i,
  output logic                 ex_valid_o,
  output alu_operator_e        ex_operator_o,
  output logic [Width-1:0]     ex_operand_a_o,
  output logic [Width-1:0]     ex_operand_b_o,
  output logic [Width-1:0]     ex_rs2_data_o,
  output logic [4:0]           ex_rd_o,
  output logic                 ex_rd_we_o,
  output logic                 ex_is_load_o
);

  logic             hazard;
  logic             transfer;
  logic             ex_fwd_en;
  logic [Width-1:0] rs1_val;
  logic [Width-1:0] rs2_val;
  logic [Width-1:0] op_a;
  logic [Width-1:0] op_b;

  // A load's data only exists in WB, so a dependent reader must wait one cycle.
  // Loads to x0 never produce a usable value and are not a hazard.
  always_comb begin
    hazard = ex_valid_o && ex_is_load_o && ex_rd_we_o && (ex_rd_o != 5'd0) &&
             ((id_rs_used_i[0] && (id_rs1_i == ex_rd_o)) ||
              (id_rs_used_i[1] && (id_rs2_i == ex_rd_o)));
  end

  assign id_ready_o = !flush_i && !hazard && (!ex_valid_o || ex_ready_i);
  assign transfer   = id_valid_i && id_ready_o;

  // The ALU result is only meaningful for non-load instructions held in EX.
  assign ex_fwd_en = ex_valid_o && ex_rd_we_o && !ex_is_load_o;

  // Priority: x0, then EX (younger), then WB, then register file.
  always_comb begin
    rs1_val = rf_rdata_a_i;
    if (id_rs1_i == 5'd0) begin
      rs1_val = '0;
    end else if (ex_fwd_en && (ex_rd_o == id_rs1_i)) begin
      rs1_val = alu_result_i;
    end else if (wb_we_i && (wb_rd_i == id_rs1_i)) begin
      rs1_val = wb_data_i;
    end
  end

  always_comb begin
    rs2_val = rf_rdata_b_i;
    if (id_rs2_i == 5'd0) begin
      rs2_val = '0;
    end else if (ex_fwd_en && (ex_rd_o == id_rs2_i)) begin
      rs2_val = alu_result_i;
    end else if (wb_we_i && (wb_rd_i == id_rs2_i)) begin
      rs2_val = wb_data_i;
    end
  end

  assign op_a = id_op_a_sel_i ? id_pc_i  : rs1_val;
  assign op_b = id_op_b_sel_i ? id_imm_i : rs2_val;

  // Flush only clears the valid bit; payload may hold stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o     <= 1'b0;
      ex_operator_o  <= ALU_ADD;
      ex_operand_a_o <= '0;
      ex_operand_b_o <= '0;
      ex_rs2_data_o  <= '0;
      ex_rd_o        <= 5'd0;
      ex_rd_we_o     <= 1'b0;
      ex_is_load_o   <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (transfer) begin
      ex_valid_o     <= 1'b1;
      ex_operator_o  <= id_operator_i;
      ex_operand_a_o <= op_a;
      ex_operand_b_o <= op_b;
      ex_rs2_data_o  <= rs2_val;
      ex_rd_o        <= id_rd_i;
      ex_rd_we_o     <= id_rd_we_i;
      ex_is_load_o   <= id_is_load_i;
    end else if (ex_valid_o && ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule
